// File: rtl/frame_update_sequencer.sv
// Once-per-frame update sequencer: starts each update stage in turn during vertical
// blanking, waits for its done with a timeout guard, and tracks overruns and errors.
module frame_update_sequencer #(
  parameter int STAGES  = 3,
  parameter int TIMEOUT = 4000,
  parameter int FCW     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              frame_tick_i,
  input  logic              pause_i,
  input  logic              clear_err_i,
  input  logic [STAGES-1:0] stage_done_i,
  output logic [STAGES-1:0] stage_start_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [FCW-1:0]    frame_count_o,
  output logic [7:0]        overrun_count_o,
  output logic [STAGES-1:0] timeout_err_o
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [STAGES-1:0] FIRST = STAGES'(1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;

  state_e            state_q;
  logic [IW-1:0]     idx_q;
  logic [TW-1:0]     timer_q;
  logic              pending_q;
  logic [STAGES-1:0] stage_start_q;
  logic [STAGES-1:0] timeout_err_q;
  logic              busy_q;
  logic              frame_done_q;
  logic [FCW-1:0]    frame_count_q;
  logic [7:0]        overrun_q;

  logic          done_hit;
  logic          timed_out;
  logic          last_stage;
  logic          start_ok;
  logic [IW-1:0] idx_d;

  assign done_hit   = stage_done_i[idx_q];
  assign timed_out  = (timer_q == TW'(TIMEOUT - 1));
  assign last_stage = (idx_q == IW'(STAGES - 1));
  assign start_ok   = (frame_tick_i | pending_q) & ~pause_i;
  assign idx_d      = idx_q + IW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      stage_start_q <= '0;
      timeout_err_q <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= '0;
    end else begin
      stage_start_q <= '0;
      frame_done_q  <= 1'b0;
      if (clear_err_i) begin
        timeout_err_q <= '0;
        overrun_q     <= '0;
      end
      // A tick that cannot launch is parked once; any further one is lost and counted.
      if (frame_tick_i && state_q != IDLE) begin
        if (!pending_q) pending_q <= 1'b1;
        else            overrun_q <= (overrun_q == 8'hFF) ? 8'hFF : overrun_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q       <= LAUNCH;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            stage_start_q <= FIRST;
            busy_q        <= 1'b1;
          end
        end
        LAUNCH: begin
          state_q <= WAIT;
          timer_q <= '0;
        end
        WAIT: begin
          // A done on the timeout cycle still counts as a clean completion.
          if (done_hit || timed_out) begin
            if (!done_hit) timeout_err_q[idx_q] <= 1'b1;
            if (last_stage) begin
              state_q <= DONE;
            end else begin
              state_q       <= LAUNCH;
              idx_q         <= idx_d;
              stage_start_q <= FIRST << idx_d;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DONE: begin
          state_q       <= IDLE;
          busy_q        <= 1'b0;
          frame_done_q  <= 1'b1;
          frame_count_q <= frame_count_q + FCW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stage_start_o   = stage_start_q;
  assign busy_o          = busy_q;
  assign frame_done_o    = frame_done_q;
  assign frame_count_o   = frame_count_q;
  assign overrun_count_o = overrun_q;
  assign timeout_err_o   = timeout_err_q;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Bench for frame_update_sequencer: directed scenarios plus random traffic, each
// cycle compared against a stage/age reference model of the frame schedule.
`timescale 1ns/1ps
module tb_frame_update_sequencer;
  localparam int STAGES  = 3;
  localparam int TIMEOUT = 8;
  localparam int FCW     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_tick = 1'b0;
  logic              pause = 1'b0;
  logic              clear_err = 1'b0;
  logic [STAGES-1:0] stage_done = '0;
  logic [STAGES-1:0] stage_start;
  logic              busy;
  logic              frame_done;
  logic [FCW-1:0]    frame_count;
  logic [7:0]        overrun_count;
  logic [STAGES-1:0] timeout_err;

  always #5 clk = ~clk;

  frame_update_sequencer #(.STAGES(STAGES), .TIMEOUT(TIMEOUT), .FCW(FCW)) dut (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(frame_tick), .pause_i(pause),
    .clear_err_i(clear_err), .stage_done_i(stage_done), .stage_start_o(stage_start),
    .busy_o(busy), .frame_done_o(frame_done), .frame_count_o(frame_count),
    .overrun_count_o(overrun_count), .timeout_err_o(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is a walk over stages; age counts cycles since a stage's start.
  bit                m_active, m_finishing, m_pending, m_fdone;
  int                m_stage, m_age, m_fcount, m_ovf;
  logic [STAGES-1:0] m_err;

  int lat [STAGES];     // cycles after its start that a stage answers; -1 = never
  bit noise = 1'b0;
  int cyc = 0;
  int start_cyc [STAGES];
  int fdone_cyc = -1;

  function automatic void model_reset();
    m_active = 0; m_finishing = 0; m_pending = 0; m_fdone = 0;
    m_stage = 0; m_age = 0; m_fcount = 0; m_ovf = 0; m_err = '0;
  endfunction

  function automatic void model_step(input bit tk, input bit ps, input bit ce,
                                     input logic [STAGES-1:0] dn);
    logic [STAGES-1:0] set_err = '0;
    bit ovf_inc = 0;
    m_fdone = 0;
    if (!m_active) begin
      if ((tk || m_pending) && !ps) begin
        m_active = 1; m_finishing = 0; m_stage = 0; m_age = 0; m_pending = 0;
      end
    end else begin
      if (tk) begin
        if (m_pending) ovf_inc = 1;
        else           m_pending = 1;
      end
      if (m_finishing) begin
        m_active = 0; m_finishing = 0; m_fdone = 1;
        m_fcount = (m_fcount + 1) % (1 << FCW);
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (dn[m_stage] || m_age == TIMEOUT) begin
        if (!dn[m_stage]) set_err[m_stage] = 1'b1;
        if (m_stage == STAGES - 1) m_finishing = 1;
        else begin m_stage++; m_age = 0; end
      end else begin
        m_age++;
      end
    end
    m_err = ce ? set_err : (m_err | set_err);
    if (ovf_inc)  m_ovf = (m_ovf == 255) ? 255 : m_ovf + 1;
    else if (ce)  m_ovf = 0;
  endfunction

  function automatic logic [STAGES-1:0] gen_done();
    logic [STAGES-1:0] d = '0;
    if (m_active && !m_finishing && lat[m_stage] >= 0 && m_age == lat[m_stage])
      d[m_stage] = 1'b1;
    if (noise && $urandom_range(0, 3) == 0) d = d | STAGES'($urandom);
    return d;
  endfunction

  task automatic check_outputs();
    logic [31:0] es = 0;
    if (m_active && !m_finishing && m_age == 0) es = 32'(1) << m_stage;
    check_eq("stage_start", 32'(stage_start), es);
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("frame_done", 32'(frame_done), 32'(m_fdone));
    check_eq("frame_count", 32'(frame_count), 32'(m_fcount));
    check_eq("overrun", 32'(overrun_count), 32'(m_ovf));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_err));
    for (int k = 0; k < STAGES; k++) if (stage_start[k]) start_cyc[k] = cyc;
    if (frame_done) fdone_cyc = cyc;
  endtask

  task automatic cycle(input bit tk, input bit ps, input bit ce, input logic [STAGES-1:0] xd);
    @(negedge clk);
    check_outputs();
    frame_tick = tk; pause = ps; clear_err = ce;
    stage_done = gen_done() | xd;
    @(posedge clk);
    model_step(tk, ps, ce, stage_done);
    cyc++;
  endtask

  task automatic idle_cycles(input int n, input bit ps);
    for (int i = 0; i < n; i++) cycle(1'b0, ps, 1'b0, '0);
  endtask

  task automatic clear_marks();
    for (int k = 0; k < STAGES; k++) start_cyc[k] = -1;
    fdone_cyc = -1;
  endtask

  int t;
  bit tk, ps, ce;

  initial begin
    model_reset();
    lat = '{3, 3, 3};
    clear_marks();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Nominal frame, each stage answering 3 cycles after its start.
    clear_marks();
    t = cyc;
    cycle(1'b1, 1'b0, 1'b0, '0);
    idle_cycles(19, 1'b0);
    check_eq("t1_start0", start_cyc[0] - t, 1);
    check_eq("t1_start1", start_cyc[1] - t, 5);
    check_eq("t1_start2", start_cyc[2] - t, 9);
    check_eq("t1_fdone", fdone_cyc - t, 14);
    #1 check_eq("t1_count", 32'(frame_count), 1);

    // Stage 1 never answers: timeout then stage 2.
    lat = '{2, -1, 2};
    clear_marks();
    cycle(1'b1, 1'b0, 1'b0, '0);
    idle_cycles(39, 1'b0);
    check_eq("t2_gap", start_cyc[2] - start_cyc[1], 9);
    #1 check_eq("t2_err", 32'(timeout_err), 32'b010);
    cycle(1'b0, 1'b0, 1'b1, '0);
    #1 check_eq("t2_clr", 32'(timeout_err), 0);

    // Three ticks during one frame: one parked, two lost.
    lat = '{3, 3, 3};
    clear_marks();
    t = cyc;
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
    end
    #1 check_eq("t3_ovr", 32'(overrun_count), 2);
    idle_cycles(13, 1'b0);
    check_eq("t3_relaunch", start_cyc[0] - t, 15);
    idle_cycles(20, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, '0);

    // Pause: tick in IDLE dropped; pause mid-frame lets the frame finish.
    clear_marks();
    cycle(1'b1, 1'b1, 1'b0, '0);
    idle_cycles(5, 1'b1);
    check_eq("t4_nostart", start_cyc[0], -1);
    #1 check_eq("t4_ovr", 32'(overrun_count), 0);
    t = cyc;
    cycle(1'b1, 1'b0, 1'b0, '0);
    idle_cycles(19, 1'b1);
    check_eq("t4_fdone", fdone_cyc - t, 14);
    idle_cycles(2, 1'b0);

    // Stray dones: wrong bit while waiting, and a done during the start cycle.
    lat = '{-1, -1, -1};
    clear_marks();
    t = cyc;
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 3'b001);
    cycle(1'b0, 1'b0, 1'b0, 3'b100);
    cycle(1'b0, 1'b0, 1'b0, 3'b001);
    lat = '{-1, 1, 1};
    idle_cycles(16, 1'b0);
    check_eq("t6_start1", start_cyc[1] - t, 4);
    check_eq("t6_start0", start_cyc[0] - t, 1);

    // Reset in the middle of stage 1's wait, with a tick parked.
    lat = '{2, -1, 2};
    cycle(1'b1, 1'b0, 1'b0, '0);
    idle_cycles(3, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    idle_cycles(3, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    frame_tick = 1'b0; pause = 1'b0; clear_err = 1'b0; stage_done = '0;
    #1;
    check_eq("t5_start", 32'(stage_start), 0);
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_count", 32'(frame_count), 0);
    check_eq("t5_err", 32'(timeout_err), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(3, 1'b0);
    clear_marks();
    t = cyc;
    cycle(1'b1, 1'b0, 1'b0, '0);
    idle_cycles(4, 1'b0);
    check_eq("t5_restart", start_cyc[0] - t, 1);
    idle_cycles(30, 1'b0);

    // Overrun saturation, then clear.
    lat = '{-1, -1, -1};
    for (int i = 0; i < 400; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    #1 check_eq("sat_ovr", 32'(overrun_count), 255);
    cycle(1'b0, 1'b0, 1'b1, '0);
    #1 check_eq("sat_clr", 32'(overrun_count), 0);
    idle_cycles(40, 1'b0);

    // Random traffic against the model.
    noise = 1'b1;
    ps = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0)
        for (int k = 0; k < STAGES; k++) lat[k] = int'($urandom_range(0, 10));
      tk = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) ps = ~ps;
      ce = !tk && ($urandom_range(0, 39) == 0);
      cycle(tk, ps, ce, '0);
    end
    cycle(1'b0, 1'b0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
